// File: rtl/alu_scheduler.sv
// Shares one external combinational 8-bit ALU between two requesters. The block arbitrates
// round-robin, runs one operation at a time and returns each result on a per-requester handshake.
module alu_scheduler #(
  parameter logic [7:0] DIV_ZERO_VAL = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_sel,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] SelDiv = 4'b0011;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic       g_q;
  logic       grant;
  logic       accept;
  logic [7:0] a_q, b_q;
  logic [3:0] sel_q;
  logic [7:0] data_q;
  logic       carry_q;
  logic       err_q;
  logic       div_zero;

  assign div_zero = (sel_q == SelDiv) && (b_q == 8'h00);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant     = 1'b0;
    accept    = 1'b0;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      StIdle: begin
        // Held off while reset is asserted so req_ready shows its reset value.
        if (!rst && (req_valid != 2'b00)) begin
          grant            = (req_valid == 2'b11) ? rr_q : req_valid[1];
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_d          = StExec;
        end
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        rsp_valid[g_q] = 1'b1;
        if (rsp_ready[g_q]) begin
          rr_d    = ~g_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      g_q     <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      sel_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (accept) begin
        g_q   <= grant;
        a_q   <= grant ? req_a[15:8] : req_a[7:0];
        b_q   <= grant ? req_b[15:8] : req_b[7:0];
        sel_q <= grant ? req_sel[7:4] : req_sel[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= 8'h00;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (state_q == StExec) begin
      if (div_zero) begin
        data_q  <= DIV_ZERO_VAL;
        carry_q <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        data_q  <= alu_out;
        carry_q <= alu_carry;
        err_q   <= 1'b0;
      end
    end
  end

  // ALU inputs come straight from the operand latches so they only move on acceptance.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_carry;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  alu_scheduler #(.DIV_ZERO_VAL(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // Stand-in ALU; a real divider gives 0 for B == 0, which the scheduler must override.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    case (s)
      4'd0:    alu_f = a + b;
      4'd1:    alu_f = a - b;
      4'd2:    alu_f = a & b;
      4'd3:    alu_f = (b == 8'h00) ? 8'h00 : a / b;
      4'd4:    alu_f = a | b;
      4'd5:    alu_f = a ^ b;
      4'd6:    alu_f = a << 1;
      default: alu_f = ~a;
    endcase
  endfunction

  function automatic logic carry_f(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    carry_f = sum[8];
  endfunction

  assign alu_out   = alu_f(alu_a, alu_b, alu_sel);
  assign alu_carry = carry_f(alu_a, alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s);
    if (i == 0) begin
      req_a[7:0] = a; req_b[7:0] = b; req_sel[3:0] = s;
    end else begin
      req_a[15:8] = a; req_b[15:8] = b; req_sel[7:4] = s;
    end
  endtask

  // Transaction-level model: a request is taken when the model says it should be, the
  // response must appear two cycles later with the spec result, and it retires on rsp_ready.
  initial begin : compare
    bit         pend;
    int         age;
    bit         eg;
    bit         mrr;
    logic [1:0] er;
    logic [7:0] ea, eb, ed;
    logic [3:0] es;
    logic       ec, ee;
    pend = 0; age = 0; eg = 0; mrr = 0;
    ea = 8'h00; eb = 8'h00; es = 4'h0; ed = 8'h00; ec = 1'b0; ee = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; mrr = 0; ea = 8'h00; eb = 8'h00; es = 4'h0;
        chk("m_rst_req_ready", req_ready, 2'b00);
        chk("m_rst_rsp_valid", rsp_valid, 2'b00);
        chk("m_rst_busy", busy, 1'b0);
        chk("m_rst_rsp_data", rsp_data, 8'h00);
        chk("m_rst_rsp_carry", rsp_carry, 1'b0);
        chk("m_rst_rsp_err", rsp_err, 1'b0);
        chk("m_rst_alu", {alu_a, alu_b, alu_sel}, 20'h0);
      end else if (!pend) begin
        er = 2'b00;
        if (req_valid != 2'b00) begin
          eg = (req_valid == 2'b11) ? mrr : req_valid[1];
          er[eg] = 1'b1;
        end
        chk("m_idle_req_ready", req_ready, er);
        chk("m_idle_rsp_valid", rsp_valid, 2'b00);
        chk("m_idle_busy", busy, 1'b0);
        chk("m_idle_alu_hold", {alu_a, alu_b, alu_sel}, {ea, eb, es});
        if (er != 2'b00) begin
          pend = 1; age = 0;
          ea = eg ? req_a[15:8] : req_a[7:0];
          eb = eg ? req_b[15:8] : req_b[7:0];
          es = eg ? req_sel[7:4] : req_sel[3:0];
          if (es == 4'b0011 && eb == 8'h00) begin
            ed = 8'hFF; ec = 1'b0; ee = 1'b1;
          end else begin
            ed = alu_f(ea, eb, es); ec = carry_f(ea, eb); ee = 1'b0;
          end
        end
      end else begin
        age++;
        chk("m_busy", busy, 1'b1);
        chk("m_busy_req_ready", req_ready, 2'b00);
        chk("m_alu_operands", {alu_a, alu_b, alu_sel}, {ea, eb, es});
        if (age == 1) begin
          chk("m_exec_rsp_valid", rsp_valid, 2'b00);
        end else begin
          chk("m_rsp_valid", rsp_valid, eg ? 2'b10 : 2'b01);
          chk("m_rsp_data", rsp_data, ed);
          chk("m_rsp_carry", rsp_carry, ec);
          chk("m_rsp_err", rsp_err, ee);
          if (rsp_ready[eg]) begin
            pend = 0;
            mrr = ~eg;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int acc_n;
    int acc_cyc [8];
    int acc_g [8];
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = 16'h0; req_b = 16'h0; req_sel = 8'h0;
    step(); step();
    @(negedge clk);
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    chk("reset_alu_sel", alu_sel, 4'h0);
    step();
    rst = 1'b0;

    // Single add with rsp_ready tied high.
    rsp_ready = 2'b11;
    set_req(0, 8'hD5, 8'h0A, 4'b0000);
    req_valid = 2'b01;
    @(negedge clk);
    chk("add_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    chk("add_rsp_valid", rsp_valid, 2'b01);
    chk("add_rsp_data", rsp_data, 8'hDF);
    chk("add_rsp_carry", rsp_carry, 1'b0);
    chk("add_rsp_err", rsp_err, 1'b0);
    step();

    // Carry with backpressure; requester 0 waits meanwhile.
    rsp_ready = 2'b00;
    set_req(1, 8'hF0, 8'h20, 4'b0000);
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp_req_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b01;
    set_req(0, 8'h11, 8'h22, 4'b0101);
    set_req(1, 8'h00, 8'h00, 4'b0011);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 2'b10);
      chk("bp_rsp_data", rsp_data, 8'h10);
      chk("bp_rsp_carry", rsp_carry, 1'b1);
      chk("bp_req_ready", req_ready, 2'b00);
      step();
    end
    rsp_ready = 2'b10;
    req_valid = 2'b00;
    @(negedge clk);
    chk("bp_last_rsp_valid", rsp_valid, 2'b10);
    step();
    @(negedge clk);
    chk("bp_done_rsp_valid", rsp_valid, 2'b00);
    chk("bp_done_busy", busy, 1'b0);
    step();

    // Round-robin from a fresh reset with both requesters held valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_ready = 2'b11;
    set_req(0, 8'h01, 8'h02, 4'b0000);
    set_req(1, 8'h03, 8'h04, 4'b0001);
    req_valid = 2'b11;
    acc_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && acc_n < 8) begin
        acc_cyc[acc_n] = c;
        acc_g[acc_n] = req_ready[1] ? 1 : 0;
        acc_n++;
      end
      step();
    end
    req_valid = 2'b00;
    chk("rr_count", acc_n, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < acc_n) begin
        chk("rr_grant", acc_g[k], k % 2);
        chk("rr_cycle", acc_cyc[k], 3 * k);
      end
    end
    step();

    // Divide-by-zero substitution, then a normal divide.
    set_req(0, 8'h07, 8'h00, 4'b0011);
    req_valid = 2'b01;
    @(negedge clk);
    chk("dz_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    chk("dz_rsp_data", rsp_data, 8'hFF);
    chk("dz_rsp_err", rsp_err, 1'b1);
    chk("dz_rsp_carry", rsp_carry, 1'b0);
    step();
    set_req(0, 8'hD5, 8'h0A, 4'b0011);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    @(negedge clk);
    chk("div_rsp_data", rsp_data, 8'h15);
    chk("div_rsp_err", rsp_err, 1'b0);
    step();

    // Reset while in EXEC; afterwards requester 0 wins because the pointer is back to 0.
    set_req(1, 8'h33, 8'h44, 4'b0001);
    req_valid = 2'b10;
    @(negedge clk);
    chk("rm_req_ready", req_ready, 2'b10);
    step();
    rst = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rm_rsp_valid", rsp_valid, 2'b00);
    chk("rm_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rm_no_rsp", rsp_valid, 2'b00);
    chk("rm_grant0", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step(); step(); step();

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 2'($urandom);
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) req_b[7:0] = 8'h00;
      if ($urandom_range(0, 3) == 0) req_b[15:8] = 8'h00;
      req_sel[3:0] = 4'($urandom_range(0, 7));
      req_sel[7:4] = 4'($urandom_range(0, 7));
      rsp_ready = 2'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step(); step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequences and shares the single combinational 8-bit ALU between two requesters (requester 0 and requester 1). Each requester issues an operation (A, B, 4-bit select) with a valid/ready handshake. The scheduler arbitrates round-robin, latches the operands, drives the ALU and registers the result. It returns the result on a per-requester response handshake and handles divide-by-zero itself.

## Interface
Parameters:
- DIV_ZERO_VAL, 8'hFF, result returned for select 4'b0011 with B == 0

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  2  bit i: requester i presents an operation
- req_ready  output  2  bit i: operation from requester i accepted this cycle
- req_a  input  16  operand A; requester i in bits [8i+7:8i]
- req_b  input  16  operand B; same packing as req_a
- req_sel  input  8  ALU select; requester i in bits [4i+3:4i]
- alu_a  output  8  operand A to the ALU
- alu_b  output  8  operand B to the ALU
- alu_sel  output  4  select to the ALU
- alu_out  input  8  ALU result
- alu_carry  input  1  ALU carry (unsigned carry of A+B, independent of select)
- rsp_valid  output  2  one-hot; response pending for requester i
- rsp_ready  input  2  bit i: requester i accepts its response
- rsp_data  output  8  registered result (shared by both requesters)
- rsp_carry  output  1  registered carry
- rsp_err  output  1  1 = divide-by-zero was substituted
- busy  output  1  high in EXEC and RESP

## Operation
The scheduler is a three-state FSM: IDLE, EXEC, RESP. The reset state is IDLE.

- **IDLE**
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester selected by the round-robin pointer `rr`.
  - `req_ready[g]` is asserted combinationally for the granted requester only.
  - On the handshake: latch `a`, `b`, `sel` and grant index `g`, then go to EXEC.
  - If neither requester is valid, remain in IDLE.
- **EXEC**
  - `alu_a`, `alu_b`, `alu_sel` are driven from the latched registers.
  - At the end of the cycle, register the result into `rsp_data` and `rsp_carry`:
    - Default: `rsp_data` = `alu_out`, `rsp_carry` = `alu_carry`, `rsp_err` = 0.
    - If the latched `sel` is 4'b0011 and the latched `b` is 0: `rsp_data` = DIV_ZERO_VAL, `rsp_carry` = 0, `rsp_err` = 1.
  - Go to RESP.
- **RESP**
  - `rsp_valid[g]` = 1.
  - Hold `rsp_data`, `rsp_carry` and `rsp_err` stable until `rsp_ready[g]`.
  - On `rsp_ready[g]`: clear `rsp_valid`, set `rr` = ~g, go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- **Outside EXEC**, `alu_a`, `alu_b` and `alu_sel` keep their last latched values, so the ALU inputs do not toggle.
- **`req_ready`** is 0 in EXEC and RESP. A requester held valid waits; no request is queued or dropped.
- **Changes to `req_*` inputs** after acceptance have no effect.

## Timing
Reset values:
- FSM state: IDLE.
- `rr` = 0 (requester 0 preferred first).
- `req_ready`, `rsp_valid`, `busy`, `rsp_err`, `rsp_carry`: 0.
- `rsp_data`, `alu_a`, `alu_b`: 8'h00; `alu_sel`: 4'h0.

Latency and throughput:
- Acceptance happens in cycle 0 (valid & ready).
- `rsp_valid` rises in cycle 2.
- With `rsp_ready` tied high, the response completes in cycle 2.
- Minimum issue interval is 3 cycles; the next acceptance can occur in cycle 3.

Boundary conditions:
- Both requesters held valid continuously: grants alternate 0, 1, 0, 1, … Neither requester starves.
- A single requester held valid: granted every 3 cycles, regardless of `rr`.
- `rsp_ready` already high when RESP is entered: the response completes in that same cycle.
- `rst` asserted mid-operation (EXEC or RESP): all outputs return to reset values immediately. The in-flight operation is discarded and no response is issued.
- `req_valid` deasserted after acceptance: no effect.

## Test plan
- **Reset:** `rst` pulse -> `req_ready` = 0, `rsp_valid` = 0, `busy` = 0, `rsp_data` = 8'h00, `alu_sel` = 4'h0.
- **Single add:** requester 0 sends A=8'hD5, B=8'h0A, sel=4'b0000, `rsp_ready` tied high -> `req_ready` = 2'b01 in cycle 0; `rsp_valid` = 2'b01 in cycle 2 with `rsp_data` = 8'hDF, `rsp_carry` = 0, `rsp_err` = 0.
- **Carry and backpressure:** requester 1 sends A=8'hF0, B=8'h20, sel=0; `rsp_ready` held low 4 cycles -> `rsp_valid` = 2'b10 held with `rsp_data` = 8'h10 and `rsp_carry` = 1 stable, `req_ready` = 0 throughout, completes the cycle `rsp_ready[1]` rises.
- **Round-robin:** both requesters valid continuously after reset -> acceptance order 0, 1, 0, 1 at cycles 0, 3, 6, 9.
- **Divide-by-zero:** A=8'h07, B=8'h00, sel=4'b0011 -> `rsp_data` = 8'hFF, `rsp_err` = 1, `rsp_carry` = 0. Then A=8'hD5, B=8'h0A, sel=4'b0011 -> `rsp_data` = 8'h15, `rsp_err` = 0.
- **Reset mid-op:** assert `rst` in EXEC -> no `rsp_valid` pulse. After release, a pending request from requester 1 with requester 0 also valid is granted to requester 0 (`rr` reset to 0).
